bip_sequencer: RTL and testbench

Multi-cycle control sequencer for the BIP accumulator processor. It fetches instruction words from the synchronous program memory and holds them in an instruction register. It presents the opcode to the instruction decoder, inserts a wait cycle for data-RAM reads, and issues a one-cycle execute strobe that the datapath uses to gate accumulator, RAM and PC writes. It owns the program counter, detects HALT (opcode 0), and reports run status and a cycle count to the debug/UART side.

---
 rtl/bip_sequencer.sv | 117 +++++++++++
 tb/tb_bip_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_sequencer.sv
// BIP accumulator processor control sequencer.
// Fetch/decode/dispatch FSM owning PC, IR and a saturating run-cycle counter.
module bip_sequencer #(
  parameter int NB_OPCODE  = 5,
  parameter int NB_OPERAND = 11,
  parameter int NB_INSTR   = 16,
  parameter int NB_ADDR    = 11,
  parameter int NB_COUNT   = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_INSTR-1:0]   i_pm_data,
  input  logic                  i_wr_pc,
  input  logic                  i_rd_ram,
  output logic [NB_ADDR-1:0]    o_pm_addr,
  output logic                  o_pm_en,
  output logic [NB_OPCODE-1:0]  o_opcode,
  output logic [NB_OPERAND-1:0] o_operand,
  output logic                  o_ram_rd_en,
  output logic                  o_exec,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [NB_COUNT-1:0]   o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_DISPATCH,
    S_MEMWAIT,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [NB_ADDR-1:0]  pc;
  logic [NB_INSTR-1:0] ir;
  logic [NB_COUNT-1:0] cnt;

  logic op_zero;
  logic start_ok;
  logic exec;
  logic rd_en;
  logic busy;

  assign op_zero = (ir[NB_INSTR-1 -: NB_OPCODE] == '0);

  always_comb begin
    state_nx = state;
    start_ok = 1'b0;
    exec     = 1'b0;
    rd_en    = 1'b0;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (i_start) begin
          start_ok = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_FETCH:  state_nx = S_DECODE;
      S_DECODE: state_nx = S_DISPATCH;
      S_DISPATCH: begin
        if (op_zero) begin
          state_nx = S_HALT;
        end else if (i_rd_ram) begin
          rd_en    = 1'b1;
          state_nx = S_MEMWAIT;
        end else begin
          exec     = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_MEMWAIT: begin
        exec     = 1'b1;
        state_nx = S_FETCH;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_FETCH) || (state == S_DECODE) ||
                (state == S_DISPATCH) || (state == S_MEMWAIT);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_DECODE) ir <= i_pm_data;
      if (start_ok) begin
        pc  <= '0;
        cnt <= '0;
      end else begin
        // PC commits only on the edge that closes the exec cycle
        if (exec && i_wr_pc) pc <= pc + NB_ADDR'(1);
        if (busy && (cnt != '1)) cnt <= cnt + NB_COUNT'(1);
      end
    end
  end

  assign o_pm_addr     = pc;
  assign o_pm_en       = (state == S_FETCH);
  assign o_opcode      = ir[NB_INSTR-1 -: NB_OPCODE];
  assign o_operand     = ir[NB_OPERAND-1:0];
  assign o_ram_rd_en   = rd_en;
  assign o_exec        = exec;
  assign o_busy        = busy;
  assign o_done        = (state == S_HALT);
  assign o_cycle_count = cnt;

endmodule

// File: tb/tb_bip_sequencer.sv
// Bench for bip_sequencer: exec scoreboard, program table, timing sequences.
// A second small instance covers PC wrap and counter saturation.
module tb_bip_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n_exec = 0;

  // big instance
  logic        rst_n, start, wr_pc, rd_ram;
  logic [15:0] pm_data;
  logic [10:0] pm_addr;
  logic        pm_en, ram_rd_en, exec, busy, done;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic [31:0] count;
  logic [15:0] pm [0:2047];

  bip_sequencer u_dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start),
    .i_pm_data(pm_data), .i_wr_pc(wr_pc), .i_rd_ram(rd_ram),
    .o_pm_addr(pm_addr), .o_pm_en(pm_en), .o_opcode(opcode),
    .o_operand(operand), .o_ram_rd_en(ram_rd_en), .o_exec(exec),
    .o_busy(busy), .o_done(done), .o_cycle_count(count)
  );

  // small instance: 3-bit PC, 4-bit counter
  logic        s_rst_n, s_start, s_wr_pc, s_rd_ram;
  logic [15:0] s_pm_data;
  logic [2:0]  s_pm_addr;
  logic        s_pm_en, s_ram_rd_en, s_exec, s_busy, s_done;
  logic [4:0]  s_opcode;
  logic [10:0] s_operand;
  logic [3:0]  s_count;
  logic [15:0] pm_s [0:7];

  bip_sequencer #(.NB_ADDR(3), .NB_COUNT(4)) u_small (
    .i_clock(clk), .i_reset(s_rst_n), .i_start(s_start),
    .i_pm_data(s_pm_data), .i_wr_pc(s_wr_pc), .i_rd_ram(s_rd_ram),
    .o_pm_addr(s_pm_addr), .o_pm_en(s_pm_en), .o_opcode(s_opcode),
    .o_operand(s_operand), .o_ram_rd_en(s_ram_rd_en), .o_exec(s_exec),
    .o_busy(s_busy), .o_done(s_done), .o_cycle_count(s_count)
  );

  // decoder model: opcode 2 reads RAM, opcode 31 holds PC
  function automatic logic dec_wr(input logic [4:0] op);
    return (op != 5'd0) && (op != 5'd31);
  endfunction
  function automatic logic dec_rd(input logic [4:0] op);
    return op == 5'd2;
  endfunction

  always_comb begin
    wr_pc    = dec_wr(opcode);
    rd_ram   = dec_rd(opcode);
    s_wr_pc  = dec_wr(s_opcode);
    s_rd_ram = dec_rd(s_opcode);
  end

  always @(posedge clk) begin
    if (pm_en) pm_data <= pm[pm_addr];
    if (s_pm_en) s_pm_data <= pm_s[s_pm_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // scoreboard of expected exec commits
  typedef struct packed {
    logic [10:0] addr;
    logic [15:0] word;
  } exp_t;
  exp_t sb[$];
  logic prev_exec = 1'b0;

  always @(negedge clk) begin
    if (exec) begin
      n_exec++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL sb_unexpected_exec addr=%0h", pm_addr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_exec", {37'd0, pm_addr, opcode, operand},
            {37'd0, e.addr, e.word});
      end
      chk("exec_vs_rd", {63'd0, ram_rd_en}, 64'd0);
      chk("exec_back2back", {63'd0, prev_exec}, 64'd0);
    end
    prev_exec = exec;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model();
    logic [10:0] p;
    logic [15:0] w;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      w = pm[p];
      if (w[15:11] == 5'd0) break;
      sb.push_back({p, w});
      if (dec_wr(w[15:11])) p = p + 11'd1;
    end
  endtask

  task automatic load(input logic [3:0][15:0] prog);
    for (int i = 0; i < 2048; i++) pm[i] = 16'h0000;
    for (int i = 0; i < 4; i++) pm[i] = prog[i];
  endtask

  task automatic big_reset();
    rst_n = 1'b0;
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    sb.delete();
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_halt(input string nm);
    for (int k = 0; k < 300; k++) begin
      if (done) break;
      tick();
    end
    chk(nm, {63'd0, done}, 64'd1);
  endtask

  function automatic logic [63:0] outs();
    return {pm_addr, pm_en, opcode, operand, ram_rd_en, exec,
            busy, done, count};
  endfunction

  typedef struct {
    logic [3:0][15:0] prog;
    logic [10:0]      pc;
    logic [31:0]      cnt;
  } vec_t;
  vec_t vt[4];

  initial begin
    vt[0] = '{prog: {16'h0, 16'h0, 16'h0, 16'h1805}, pc: 11'd1, cnt: 6};
    vt[1] = '{prog: {16'h0, 16'h0, 16'h2803, 16'h1007}, pc: 11'd2,
              cnt: 10};
    vt[2] = '{prog: {16'h0, 16'h0, 16'h1007, 16'hF000}, pc: 11'd2,
              cnt: 10};
    vt[3] = '{prog: {16'h0, 16'h0, 16'h0, 16'h0}, pc: 11'd0, cnt: 3};

    s_rst_n = 1'b0;
    s_start = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < 8; i++) pm_s[i] = 16'h2803;
    load({16'h0, 16'h0, 16'h0, 16'h0});

    // reset and idle
    tick(); tick();
    chk("reset_outs", outs(), 64'd0);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("idle_outs", outs(), 64'd0);

    // straight-line program, exec timing
    load({16'h0, 16'h0000, 16'h2803, 16'h1805});
    push_model();
    go();
    chk("fetch0", {52'd0, pm_en, pm_addr}, {52'd0, 1'b1, 11'd0});
    for (int k = 1; k <= 9; k++) begin
      chk($sformatf("exec_c%0d", k), {63'd0, exec},
          {63'd0, (k == 3 || k == 6)});
      if (k == 3) chk("ldi_fields", {48'd0, opcode, operand},
                      {48'd0, 5'd3, 11'd5});
      tick();
    end
    chk("halt_done", {62'd0, done, busy}, {62'd0, 2'b10});
    chk("halt_pc", {53'd0, pm_addr}, 64'd2);
    chk("halt_count", {32'd0, count}, 64'd9);
    tick();
    chk("halt_frozen", {21'd0, pm_addr, count}, {21'd0, 11'd2, 32'd9});

    // restart from HALT with start held across busy states
    push_model();
    start = 1'b1;
    tick();
    chk("restart", {19'd0, done, pm_en, pm_addr, count},
        {19'd0, 1'b0, 1'b1, 11'd0, 32'd0});
    tick(); tick();
    chk("restart_exec", {63'd0, exec}, 64'd1);
    start = 1'b0;
    tick();
    chk("restart_next", {20'd0, pm_en, pm_addr, count},
        {20'd0, 1'b1, 11'd1, 32'd3});
    run_halt("restart_halt");
    chk("restart_count", {32'd0, count}, 64'd9);
    chk("restart_sb", 64'(sb.size()), 64'd0);

    // memory-read instruction timing
    big_reset();
    load({16'h0, 16'h0, 16'h0000, 16'h1007});
    push_model();
    go();
    tick(); tick();
    chk("ld_c3", {51'd0, ram_rd_en, exec, operand},
        {51'd0, 1'b1, 1'b0, 11'd7});
    tick();
    chk("ld_c4", {62'd0, ram_rd_en, exec}, {62'd0, 2'b01});
    tick();
    chk("ld_c5", {52'd0, pm_en, pm_addr}, {52'd0, 1'b1, 11'd1});
    run_halt("ld_halt");
    chk("ld_count", {32'd0, count}, 64'd7);

    // reset while in DISPATCH of a load
    big_reset();
    go();
    tick(); tick();
    chk("abort_in_dispatch", {63'd0, ram_rd_en}, 64'd1);
    begin
      int e0;
      e0 = n_exec;
      rst_n = 1'b0;
      #1;
      chk("abort_outs", outs(), 64'd0);
      tick(); tick();
      chk("abort_no_exec", 64'(n_exec), 64'(e0));
      rst_n = 1'b1;
      tick();
      chk("abort_idle", outs(), 64'd0);
    end

    // program table
    for (int v = 0; v < 4; v++) begin
      big_reset();
      load(vt[v].prog);
      push_model();
      go();
      run_halt($sformatf("tab%0d_halt", v));
      chk($sformatf("tab%0d_pc", v), {53'd0, pm_addr}, {53'd0, vt[v].pc});
      chk($sformatf("tab%0d_cnt", v), {32'd0, count}, {32'd0, vt[v].cnt});
      chk($sformatf("tab%0d_sb", v), 64'(sb.size()), 64'd0);
    end

    // small instance: PC wrap and counter saturation
    rst_n = 1'b0;
    s_rst_n = 1'b1;
    tick();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      if (k == 15) chk("sat_c15", {60'd0, s_count}, 64'd14);
      if (k == 16) chk("sat_c16", {60'd0, s_count}, 64'd15);
      if (k == 19) chk("sat_c19", {60'd0, s_count}, 64'd15);
      if (k == 22) chk("wrap_pc7", {60'd0, s_pm_en, s_pm_addr},
                       {60'd0, 1'b1, 3'd7});
      if (k == 25) chk("wrap_pc0", {60'd0, s_pm_en, s_pm_addr},
                       {60'd0, 1'b1, 3'd0});
      if (k == 28) chk("sat_c28", {60'd0, s_count}, 64'd15);
      tick();
    end

    // small instance: i_wr_pc=0 refetches same address
    s_rst_n = 1'b0;
    tick();
    s_rst_n = 1'b1;
    pm_s[0] = 16'hF800;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    tick(); tick();
    chk("hold_exec", {63'd0, s_exec}, 64'd1);
    tick();
    chk("hold_c4", {60'd0, s_pm_en, s_pm_addr}, {60'd0, 1'b1, 3'd0});
    tick(); tick(); tick();
    chk("hold_c7", {60'd0, s_pm_en, s_pm_addr}, {60'd0, 1'b1, 3'd0});
    chk("hold_busy", {62'd0, s_busy, s_done}, {62'd0, 2'b10});

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
